// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int unsigned PC_W        = 32;
    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // FSM state encoding is visible on state_o, so values are fixed.
    typedef enum logic [2:0] {
        ST_BOOT     = 3'd0,
        ST_RUN      = 3'd1,
        ST_WAIT_MEM = 3'd2,
        ST_FLUSH    = 3'd3,
        ST_HALT     = 3'd4
    } state_t;

    // Next-PC source selection.
    typedef enum logic [1:0] {
        SEL_HOLD   = 2'd0,
        SEL_SEQ    = 2'd1,
        SEL_BRANCH = 2'd2
    } pc_sel_t;

    // Redirect targets are forced onto an instruction boundary.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register with sequential / branch / hold next-PC mux.
module fetch_pc_reg
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  pc_sel_t     sel,
    input  logic [31:0] target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic [31:0] pc_next;

    // Sequential address wraps modulo 2^32.
    assign pc_plus4 = pc + 32'(INSTR_BYTES);

    // Next-PC mux; hold keeps the current value.
    always_comb begin
        pc_next = pc;
        case (sel)
            SEL_SEQ:    pc_next = pc_plus4;
            SEL_BRANCH: pc_next = target;
            default:    pc_next = pc;
        endcase
    end

    // PC state, loaded only when a new source is selected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (sel != SEL_HOLD) begin
            pc <= pc_next;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC sequencer: owns the PC, drives the imem request and IF/ID flush.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             branch_taken_i,
    input  logic [31:0]      branch_target_i,
    input  logic             halt_i,
    input  logic             resume_i,
    input  logic             imem_ready_i,
    output logic             imem_req_o,
    output logic [31:0]      pc_o,
    output logic [31:0]      pc_plus4_o,
    output logic             instr_valid_o,
    output logic             flush_o,
    output logic             misalign_o,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] fetch_count_o
);

    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    state_t      state;
    logic [2:0]  flush_cnt;
    logic        accept;
    logic        redirect;
    pc_sel_t     pc_sel;
    logic [31:0] target_aligned;

    assign target_aligned = align_pc(branch_target_i);
    assign state_o        = state;
    assign instr_valid_o  = accept;

    // Fetch acceptance, redirect detection and next-PC source per state.
    always_comb begin
        accept   = 1'b0;
        redirect = 1'b0;
        pc_sel   = SEL_HOLD;
        case (state)
            ST_RUN, ST_WAIT_MEM: begin
                redirect = branch_taken_i;
                accept   = imem_ready_i & ~stall_i & ~branch_taken_i & ~halt_i;
            end
            ST_FLUSH: redirect = branch_taken_i;
            default: begin
                accept   = 1'b0;
                redirect = 1'b0;
            end
        endcase
        if (redirect) begin
            pc_sel = SEL_BRANCH;
        end else if (accept) begin
            pc_sel = SEL_SEQ;
        end
    end

    fetch_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel      (pc_sel),
        .target   (target_aligned),
        .pc       (pc_o),
        .pc_plus4 (pc_plus4_o)
    );

    // Sticky misalignment flag and retired-fetch counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_o    <= 1'b0;
            fetch_count_o <= '0;
        end else begin
            if (redirect && (branch_target_i[1:0] != 2'b00)) begin
                misalign_o <= 1'b1;
            end
            if (accept) begin
                fetch_count_o <= fetch_count_o + CNT_W'(1);
            end
        end
    end

    // FSM with request/flush outputs registered alongside each transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_BOOT;
            flush_cnt  <= 3'd0;
            flush_o    <= 1'b0;
            imem_req_o <= 1'b0;
        end else begin
            case (state)
                ST_BOOT: begin
                    state      <= ST_RUN;
                    imem_req_o <= 1'b1;
                    flush_o    <= 1'b0;
                end
                ST_RUN, ST_WAIT_MEM: begin
                    if (branch_taken_i) begin
                        state      <= ST_FLUSH;
                        flush_cnt  <= FLUSH_LAST;
                        flush_o    <= 1'b1;
                        imem_req_o <= 1'b0;
                    end else if (halt_i) begin
                        state      <= ST_HALT;
                        imem_req_o <= 1'b0;
                    end else if (stall_i) begin
                        // Stall holds whichever fetch state we are in.
                        imem_req_o <= 1'b1;
                    end else if (!imem_ready_i) begin
                        state      <= ST_WAIT_MEM;
                        imem_req_o <= 1'b1;
                    end else begin
                        state      <= ST_RUN;
                        imem_req_o <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (branch_taken_i) begin
                        flush_cnt <= FLUSH_LAST;
                    end else if (flush_cnt == 3'd0) begin
                        state      <= ST_RUN;
                        flush_o    <= 1'b0;
                        imem_req_o <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                ST_HALT: begin
                    if (resume_i) begin
                        state      <= ST_RUN;
                        imem_req_o <= 1'b1;
                    end
                end
                default: begin
                    state      <= ST_BOOT;
                    flush_o    <= 1'b0;
                    imem_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a scoreboard of expected accepted fetches.
module tb_fetch_sequencer;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             stall_i;
    logic             branch_taken_i;
    logic [31:0]      branch_target_i;
    logic             halt_i;
    logic             resume_i;
    logic             imem_ready_i;
    logic             imem_req_o;
    logic [31:0]      pc_o;
    logic [31:0]      pc_plus4_o;
    logic             instr_valid_o;
    logic             flush_o;
    logic             misalign_o;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] fetch_count_o;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] cnt;
    } fetch_exp_t;

    fetch_exp_t exp_q[$];
    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .RESET_PC     (32'h0000_0000),
        .FLUSH_CYCLES (2),
        .CNT_W        (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .halt_i          (halt_i),
        .resume_i        (resume_i),
        .imem_ready_i    (imem_ready_i),
        .imem_req_o      (imem_req_o),
        .pc_o            (pc_o),
        .pc_plus4_o      (pc_plus4_o),
        .instr_valid_o   (instr_valid_o),
        .flush_o         (flush_o),
        .misalign_o      (misalign_o),
        .state_o         (state_o),
        .fetch_count_o   (fetch_count_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_fetch(input logic [31:0] pc, input logic [31:0] cnt);
        fetch_exp_t e;
        e.pc  = pc;
        e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Mid-cycle sample point.
    task automatic mid();
        @(negedge clk);
    endtask

    // Monitor: every accepted fetch must match the next scoreboard entry.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && instr_valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL unexpected_fetch: got pc 0x%08h expected no fetch", pc_o);
                end else begin
                    fetch_exp_t e;
                    e = exp_q.pop_front();
                    check("fetch_pc", pc_o, e.pc);
                    check("fetch_cnt", 32'(fetch_count_o), e.cnt);
                end
            end
        end
    end

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        stall_i = 1'b0; branch_taken_i = 1'b0; branch_target_i = 32'h0;
        halt_i = 1'b0; resume_i = 1'b0; imem_ready_i = 1'b1;

        // Reset state
        cyc(); cyc();
        mid();
        check("rst_pc", pc_o, 32'h0);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_cnt", 32'(fetch_count_o), 32'd0);
        check("rst_req", 32'(imem_req_o), 32'd0);
        check("rst_flush", 32'(flush_o), 32'd0);
        check("rst_valid", 32'(instr_valid_o), 32'd0);
        check("rst_misalign", 32'(misalign_o), 32'd0);

        // Sequential fetch after one BOOT cycle
        cyc();
        rst_n = 1'b1;
        push_fetch(32'h0, 0); push_fetch(32'h4, 1);
        push_fetch(32'h8, 2); push_fetch(32'hC, 3);
        mid();
        check("boot_state", 32'(state_o), 32'd0);
        check("boot_req", 32'(imem_req_o), 32'd0);
        check("boot_valid", 32'(instr_valid_o), 32'd0);
        cyc(); mid();
        check("run_state", 32'(state_o), 32'd1);
        check("run_req", 32'(imem_req_o), 32'd1);
        cyc(); cyc(); cyc();

        // Branch at 0x10 to 0x40, two flush cycles
        cyc();
        branch_taken_i = 1'b1; branch_target_i = 32'h40;
        mid();
        check("pre_br_pc", pc_o, 32'h10);
        check("four_accepts", 32'(fetch_count_o), 32'd4);
        check("br_valid", 32'(instr_valid_o), 32'd0);
        cyc();
        branch_taken_i = 1'b0;
        mid();
        check("br_pc", pc_o, 32'h40);
        check("flush1", 32'(flush_o), 32'd1);
        check("flush1_state", 32'(state_o), 32'd3);
        check("flush1_req", 32'(imem_req_o), 32'd0);
        check("flush1_valid", 32'(instr_valid_o), 32'd0);
        cyc(); mid();
        check("flush2", 32'(flush_o), 32'd1);
        check("flush2_valid", 32'(instr_valid_o), 32'd0);
        cyc();
        push_fetch(32'h40, 4); push_fetch(32'h44, 5);
        mid();
        check("flush_done", 32'(flush_o), 32'd0);
        cyc();

        // Branch + stall together, misaligned target
        cyc();
        branch_taken_i = 1'b1; stall_i = 1'b1; branch_target_i = 32'h103;
        mid();
        check("pre_mis", 32'(misalign_o), 32'd0);
        cyc();
        branch_taken_i = 1'b0; stall_i = 1'b0;
        mid();
        check("mis_pc", pc_o, 32'h100);
        check("mis_set", 32'(misalign_o), 32'd1);
        cyc(); cyc();

        // Redirect to 0x20 for the memory-wait case
        branch_taken_i = 1'b1; branch_target_i = 32'h20;
        cyc();
        branch_taken_i = 1'b0;
        cyc(); cyc();
        imem_ready_i = 1'b0;
        mid();
        check("wait0_pc", pc_o, 32'h20);
        check("wait0_valid", 32'(instr_valid_o), 32'd0);
        cyc(); mid();
        check("wait1_state", 32'(state_o), 32'd2);
        check("wait1_req", 32'(imem_req_o), 32'd1);
        cyc(); mid();
        check("wait2_pc", pc_o, 32'h20);
        check("wait2_state", 32'(state_o), 32'd2);
        cyc();
        imem_ready_i = 1'b1;
        push_fetch(32'h20, 6);
        cyc();
        push_fetch(32'h24, 7);
        mid();
        check("after_wait_pc", pc_o, 32'h24);
        check("after_wait_state", 32'(state_o), 32'd1);

        // Redirect to 0x8, halt, ignored branch, resume
        cyc();
        branch_taken_i = 1'b1; branch_target_i = 32'h8;
        cyc();
        branch_taken_i = 1'b0;
        cyc(); cyc();
        halt_i = 1'b1;
        cyc();
        halt_i = 1'b0; branch_taken_i = 1'b1; branch_target_i = 32'h200;
        mid();
        check("halt_state", 32'(state_o), 32'd4);
        check("halt_req", 32'(imem_req_o), 32'd0);
        cyc(); mid();
        check("halt_pc", pc_o, 32'h8);
        check("halt_br_ign", 32'(state_o), 32'd4);
        cyc();
        branch_taken_i = 1'b0; resume_i = 1'b1; halt_i = 1'b1;
        cyc();
        resume_i = 1'b0; halt_i = 1'b0;
        push_fetch(32'h8, 8);
        mid();
        check("resume_state", 32'(state_o), 32'd1);
        check("resume_pc", pc_o, 32'h8);

        // Wrap from 0xFFFF_FFFC
        cyc();
        branch_taken_i = 1'b1; branch_target_i = 32'hFFFF_FFFC;
        cyc();
        branch_taken_i = 1'b0;
        cyc(); cyc();
        push_fetch(32'hFFFF_FFFC, 9);
        mid();
        check("wrap_plus4", pc_plus4_o, 32'h0);
        cyc();
        branch_taken_i = 1'b1; branch_target_i = 32'h300;
        mid();
        check("wrap_pc", pc_o, 32'h0);
        check("mis_sticky", 32'(misalign_o), 32'd1);

        // Async reset in the middle of a flush
        cyc();
        branch_taken_i = 1'b0;
        #1;
        check("pre_rst_flush", 32'(flush_o), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_flush", 32'(flush_o), 32'd0);
        check("arst_pc", pc_o, 32'h0);
        check("arst_state", 32'(state_o), 32'd0);
        check("arst_mis", 32'(misalign_o), 32'd0);
        check("arst_cnt", 32'(fetch_count_o), 32'd0);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
